// File: rtl/pipe_scheduler.sv
// Game-level pipe sequencer: tick divider, idle/play/over FSM, pipe slot pool
// with spaced spawning and LFSR gap heights, and a saturating score counter.
module pipe_scheduler #(
   parameter int NUM_PIPES = 3,
   parameter int TICK_DIV  = 416667,
   parameter int STEP      = 3,
   parameter int X_START   = 1023,
   parameter int SPACING   = 350,
   parameter int Y_MIN     = 300,
   parameter int BIRD_X    = 200
) (
   input  logic                      clk,
   input  logic                      RESET_N,
   input  logic                      flap,
   input  logic                      hit,
   output logic                      move,
   output logic [11*NUM_PIPES-1:0]   pipe_x,
   output logic [11*NUM_PIPES-1:0]   pipe_y,
   output logic [NUM_PIPES-1:0]      pipe_active,
   output logic [9:0]                score,
   output logic [1:0]                state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_t;

   localparam int          CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
   localparam logic [10:0] STEP_X    = 11'(STEP);
   localparam logic [10:0] X_START_X = 11'(X_START);
   localparam logic [10:0] BIRD_X_X  = 11'(BIRD_X);
   localparam logic [10:0] Y_MIN_X   = 11'(Y_MIN);
   localparam logic [11:0] SPACING_X = 12'(SPACING);
   localparam logic [10:0] X_RST     = 11'd1023;
   localparam logic [10:0] Y_RST     = 11'd320;
   localparam logic [9:0]  SCORE_MAX = 10'd999;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q;
   logic                   tick;
   logic                   move_q;
   logic [8:0]             lfsr_q;
   logic [10:0]            spawn_y;
   logic [10:0]            dist_q, dist_d;
   logic [9:0]             score_q, score_d;
   logic [NUM_PIPES-1:0]   act_q, act_d;
   logic [10:0]            x_q [NUM_PIPES];
   logic [10:0]            x_d [NUM_PIPES];
   logic [10:0]            y_q [NUM_PIPES];
   logic [10:0]            y_d [NUM_PIPES];
   logic [11:0]            dist_sum;
   logic                   spawned;

   assign tick     = (cnt_q == CNT_LAST);
   assign spawn_y  = Y_MIN_X + {3'b000, lfsr_q[7:0]};
   assign dist_sum = {1'b0, dist_q} + {1'b0, STEP_X};

   // Divider, move pulse and LFSR run in every state, independent of the FSM.
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q  <= '0;
         move_q <= 1'b0;
         lfsr_q <= 9'h1FF;
      end else begin
         cnt_q  <= tick ? '0 : cnt_q + 1'b1;
         move_q <= tick;
         lfsr_q <= {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
      end
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         dist_q  <= '0;
         score_q <= '0;
         act_q   <= '0;
         for (int i = 0; i < NUM_PIPES; i++) begin
            x_q[i] <= X_RST;
            y_q[i] <= Y_RST;
         end
      end else begin
         state_q <= state_d;
         dist_q  <= dist_d;
         score_q <= score_d;
         act_q   <= act_d;
         for (int i = 0; i < NUM_PIPES; i++) begin
            x_q[i] <= x_d[i];
            y_q[i] <= y_d[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      dist_d  = dist_q;
      score_d = score_q;
      act_d   = act_q;
      spawned = 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         x_d[i] = x_q[i];
         y_d[i] = y_q[i];
      end

      case (state_q)
         S_IDLE: begin
            if (flap) begin
               state_d  = S_PLAY;
               score_d  = '0;
               dist_d   = '0;
               act_d[0] = 1'b1;
               x_d[0]   = X_START_X;
               y_d[0]   = spawn_y;
            end
         end

         S_PLAY: begin
            // A hit beats a simultaneous tick: the field freezes where it is.
            if (hit) begin
               state_d = S_OVER;
            end else if (tick) begin
               for (int i = 0; i < NUM_PIPES; i++) begin
                  if (act_q[i]) begin
                     if (x_q[i] >= STEP_X) begin
                        x_d[i] = x_q[i] - STEP_X;
                        if ((x_q[i] >= BIRD_X_X) && ((x_q[i] - STEP_X) < BIRD_X_X)
                            && (score_d != SCORE_MAX)) begin
                           score_d = score_d + 10'd1;
                        end
                     end else begin
                        act_d[i] = 1'b0;
                     end
                  end
               end

               // Only slots free before this edge qualify, so a slot retired now waits a tick.
               if (dist_sum >= SPACING_X) begin
                  for (int i = 0; i < NUM_PIPES; i++) begin
                     if (!act_q[i] && !spawned) begin
                        spawned  = 1'b1;
                        act_d[i] = 1'b1;
                        x_d[i]   = X_START_X;
                        y_d[i]   = spawn_y;
                     end
                  end
                  dist_d = spawned ? 11'd0 : dist_q;
               end else begin
                  dist_d = dist_sum[10:0];
               end
            end
         end

         S_OVER: begin
            if (flap) begin
               state_d = S_IDLE;
               act_d   = '0;
               for (int i = 0; i < NUM_PIPES; i++) begin
                  x_d[i] = X_RST;
                  y_d[i] = Y_RST;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
      assign pipe_x[11*g +: 11] = x_q[g];
      assign pipe_y[11*g +: 11] = y_q[g];
   end

   assign pipe_active = act_q;
   assign move        = move_q;
   assign score       = score_q;
   assign state       = state_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler: a default-spacing instance for the main game
// flow, a SPACING=3 instance for pool exhaustion, and a short-track instance for score saturation.
module tb_pipe_scheduler;

   localparam int TD = 4;

   logic clk = 1'b0;
   logic RESET_N = 1'b0;
   always #5 clk = ~clk;

   logic        m_flap = 1'b0, m_hit = 1'b0, m_move;
   logic [32:0] m_x, m_y;
   logic [2:0]  m_act;
   logic [9:0]  m_score;
   logic [1:0]  m_state;

   logic        p_flap = 1'b0, p_hit = 1'b0, p_move;
   logic [32:0] p_x, p_y;
   logic [2:0]  p_act;
   logic [9:0]  p_score;
   logic [1:0]  p_state;

   logic        s_flap = 1'b0, s_hit = 1'b0, s_move;
   logic [32:0] s_x, s_y;
   logic [2:0]  s_act;
   logic [9:0]  s_score;
   logic [1:0]  s_state;

   pipe_scheduler #(.NUM_PIPES(3), .TICK_DIV(TD)) dut (
      .clk(clk), .RESET_N(RESET_N), .flap(m_flap), .hit(m_hit), .move(m_move),
      .pipe_x(m_x), .pipe_y(m_y), .pipe_active(m_act), .score(m_score), .state(m_state)
   );

   pipe_scheduler #(.NUM_PIPES(3), .TICK_DIV(TD), .SPACING(3)) dut_pool (
      .clk(clk), .RESET_N(RESET_N), .flap(p_flap), .hit(p_hit), .move(p_move),
      .pipe_x(p_x), .pipe_y(p_y), .pipe_active(p_act), .score(p_score), .state(p_state)
   );

   pipe_scheduler #(.NUM_PIPES(3), .TICK_DIV(TD), .SPACING(3), .X_START(5), .BIRD_X(3)) dut_sat (
      .clk(clk), .RESET_N(RESET_N), .flap(s_flap), .hit(s_hit), .move(s_move),
      .pipe_x(s_x), .pipe_y(s_y), .pipe_active(s_act), .score(s_score), .state(s_state)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] slot(input logic [32:0] v, input int i);
      return {21'd0, v[11*i +: 11]};
   endfunction

   // Advance to the n-th following move pulse; each wait is bounded.
   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         int b;
         b = 0;
         do begin
            @(negedge clk);
            b++;
         end while (!m_move && b < 2 * TD);
         if (!m_move) check("tick_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_state"}, m_state, 0);
      check({tag, "_act"}, m_act, 0);
      check({tag, "_score"}, m_score, 0);
      check({tag, "_move"}, m_move, 0);
      for (int i = 0; i < 3; i++) begin
         check({tag, "_x"}, slot(m_x, i), 1023);
         check({tag, "_y"}, slot(m_y, i), 320);
      end
   endtask

   initial begin : main
      int pulses, first_pulse;
      logic [31:0] y0;

      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      RESET_N = 1'b1;

      pulses = 0;
      first_pulse = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (m_move) begin
            pulses++;
            if (first_pulse == 0) first_pulse = c;
         end
      end
      check("idle_pulses", pulses, 5);
      check("idle_first_pulse", first_pulse, 4);
      check("idle_state", m_state, 0);
      check("idle_act", m_act, 0);
      check("idle_x0", slot(m_x, 0), 1023);

      // Start play just after a tick edge.
      m_flap = 1'b1;
      @(negedge clk);
      m_flap = 1'b0;
      check("start_state", m_state, 1);
      check("start_act", m_act, 3'b001);
      check("start_x0", slot(m_x, 0), 1023);
      y0 = slot(m_y, 0);
      check("start_y0_range", (y0 >= 300 && y0 <= 555), 1);

      wait_ticks(10);
      check("t10_x0", slot(m_x, 0), 993);
      check("t10_y0_held", slot(m_y, 0), y0);
      wait_ticks(106);
      check("t116_act", m_act, 3'b001);
      wait_ticks(1);
      check("t117_act", m_act, 3'b011);
      check("t117_x1", slot(m_x, 1), 1023);
      check("t117_x0", slot(m_x, 0), 672);
      wait_ticks(157);
      check("t274_x0", slot(m_x, 0), 201);
      check("t274_score", m_score, 0);
      wait_ticks(1);
      check("t275_x0", slot(m_x, 0), 198);
      check("t275_score", m_score, 1);
      wait_ticks(25);
      check("t300_score", m_score, 1);
      check("t300_act", m_act, 3'b111);

      // hit lands on the tick edge of tick 301
      repeat (TD - 1) @(negedge clk);
      m_hit = 1'b1;
      @(negedge clk);
      m_hit = 1'b0;
      check("hit_move", m_move, 1);
      check("hit_state", m_state, 2);
      check("hit_x0", slot(m_x, 0), 123);
      check("hit_x1", slot(m_x, 1), 474);
      check("hit_x2", slot(m_x, 2), 825);
      check("hit_score", m_score, 1);
      wait_ticks(2);
      check("over_x0_frozen", slot(m_x, 0), 123);
      check("over_state", m_state, 2);

      m_flap = 1'b1;
      @(negedge clk);
      m_flap = 1'b0;
      check("over2idle_state", m_state, 0);
      check("over2idle_act", m_act, 0);
      check("over2idle_score", m_score, 1);
      check("over2idle_x1", slot(m_x, 1), 1023);
      check("over2idle_y2", slot(m_y, 2), 320);

      // Restart with flap on a tick edge: no movement on that edge.
      wait_ticks(1);
      repeat (TD - 1) @(negedge clk);
      m_flap = 1'b1;
      @(negedge clk);
      m_flap = 1'b0;
      check("restart_move", m_move, 1);
      check("restart_state", m_state, 1);
      check("restart_score", m_score, 0);
      check("restart_act", m_act, 3'b001);
      check("restart_x0", slot(m_x, 0), 1023);
      wait_ticks(1);
      check("restart_t1_x0", slot(m_x, 0), 1020);

      // Pool-exhaustion and saturation instances start together.
      p_flap = 1'b1;
      s_flap = 1'b1;
      @(negedge clk);
      p_flap = 1'b0;
      s_flap = 1'b0;
      check("p_start_x0", slot(p_x, 0), 1023);
      check("s_start_x0", slot(s_x, 0), 5);
      for (int t = 1; t <= 1010; t++) begin
         wait_ticks(1);
         if (t == 1) begin
            check("s_t1_x0", slot(s_x, 0), 2);
            check("s_t1_act", s_act, 3'b011);
            check("s_t1_score", s_score, 1);
            check("p_t1_act", p_act, 3'b011);
         end
         if (t == 2) begin
            check("s_t2_act", s_act, 3'b110);
            check("s_t2_x0_kept", slot(s_x, 0), 2);
            check("s_t2_score", s_score, 2);
            check("p_t2_act", p_act, 3'b111);
            check("p_t2_x0", slot(p_x, 0), 1017);
            check("p_t2_x1", slot(p_x, 1), 1020);
            check("p_t2_x2", slot(p_x, 2), 1023);
         end
         if (t == 3) begin
            check("s_t3_act", s_act, 3'b101);
            check("s_t3_score", s_score, 3);
            check("p_t3_act", p_act, 3'b111);
            check("p_t3_x2", slot(p_x, 2), 1020);
         end
         if (t == 300) check("p_t300_score", p_score, 3);
         if (t == 341) begin
            check("p_t341_act", p_act, 3'b111);
            check("p_t341_x0", slot(p_x, 0), 0);
         end
         if (t == 342) begin
            check("p_t342_act", p_act, 3'b110);
            check("p_t342_x0_kept", slot(p_x, 0), 0);
         end
         if (t == 343) begin
            check("p_t343_act", p_act, 3'b101);
            check("p_t343_x0_reuse", slot(p_x, 0), 1023);
            check("p_t343_x1", slot(p_x, 1), 0);
         end
         if (t == 500) check("s_t500_score", s_score, 500);
         if (t == 999) check("s_t999_score", s_score, 999);
         if (t == 1010) check("s_t1010_score_sat", s_score, 999);
      end

      // Asynchronous reset in the middle of a move-high cycle.
      check("pre_rst_state", m_state, 1);
      #2;
      RESET_N = 1'b0;
      #1;
      check_reset_vals("async_rst");
      check("async_rst_s_score", s_score, 0);
      check("async_rst_p_act", p_act, 0);
      @(negedge clk);
      RESET_N = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_state", m_state, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
